// File: rtl/decomp_pkg.sv
// Shared types and constants for the decompression front end: code types, prefixes and
// code lengths of the variable-length code set.
package decomp_pkg;

    localparam int unsigned WIDTH      = 64;
    localparam int unsigned DICT_ENTRY = 16;
    localparam int unsigned WORD       = 32;
    localparam int unsigned CACHE_LINE = 128;
    localparam int unsigned IDX_W      = $clog2(DICT_ENTRY);
    localparam int unsigned LINE_WORDS = CACHE_LINE / WORD;
    localparam int unsigned BUF_W      = 2 * WIDTH;

    typedef enum logic [2:0] {
        CodeZzzz,
        CodeXxxx,
        CodeMmmm,
        CodeMmxx,
        CodeZzzx,
        CodeMmmx,
        CodeIllegal
    } code_e;

    // First two bits of every code.
    localparam logic [1:0] PfxZzzz = 2'b00;
    localparam logic [1:0] PfxXxxx = 2'b01;
    localparam logic [1:0] PfxMmmm = 2'b10;
    localparam logic [1:0] PfxExt  = 2'b11;

    // Second two bits when the prefix is 11.
    localparam logic [1:0] SfxMmxx = 2'b00;
    localparam logic [1:0] SfxZzzx = 2'b01;
    localparam logic [1:0] SfxMmmx = 2'b10;
    localparam logic [1:0] SfxIll  = 2'b11;

    localparam logic [7:0] LenZzzz = 8'd2;
    localparam logic [7:0] LenXxxx = 8'd34;
    localparam logic [7:0] LenMmmm = 8'd6;
    localparam logic [7:0] LenMmxx = 8'd24;
    localparam logic [7:0] LenZzzx = 8'd12;
    localparam logic [7:0] LenMmmx = 8'd16;
    localparam logic [7:0] LenIll  = 8'd4;

    function automatic logic [7:0] code_length(input code_e c);
        case (c)
            CodeZzzz: return LenZzzz;
            CodeXxxx: return LenXxxx;
            CodeMmmm: return LenMmmm;
            CodeMmxx: return LenMmxx;
            CodeZzzx: return LenZzzx;
            CodeMmmx: return LenMmmx;
            default:  return LenIll;
        endcase
    endfunction

endpackage

// File: rtl/decompress_stage1and2_if.sv
// Chunk-in / pair-out handshake bundle of the decompression front end.
interface decompress_stage1and2_if;
    import decomp_pkg::*;

    logic             i_valid;
    logic [WIDTH-1:0] i_chunk;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_word;
    logic             i_ready;
    logic             o_line_done;
    logic             o_error;

    modport slave (
        input  i_valid, i_chunk, i_ready,
        output o_ready, o_valid, o_word, o_line_done, o_error
    );

    modport master (
        output i_valid, i_chunk, i_ready,
        input  o_ready, o_valid, o_word, o_line_done, o_error
    );
endinterface

// File: rtl/decomp_dictionary.sv
// 16x32 dictionary with FIFO replacement, one write port and one combinational read port.
// Optional: DECOMP_DICT_DEBUG_EN adds the flattened view of all entries.
module decomp_dictionary
    import decomp_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_we,
    input  logic [WORD-1:0]            i_wdata,
    input  logic [IDX_W-1:0]           i_raddr,
    output logic [WORD-1:0]            o_rdata
`ifdef DECOMP_DICT_DEBUG_EN
    ,
    output logic [DICT_ENTRY*WORD-1:0] o_flat
`endif
);

    logic [WORD-1:0]  mem_q [DICT_ENTRY];
    logic [WORD-1:0]  mem_d [DICT_ENTRY];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;

    // Next push overwrites the oldest entry; pointer wraps naturally at 16.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (i_we) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    // Entry and pointer registers, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int unsigned i = 0; i < DICT_ENTRY; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign o_rdata = mem_q[i_raddr];

`ifdef DECOMP_DICT_DEBUG_EN
    // Entry 0 in the LSBs.
    always_comb begin
        o_flat = '0;
        for (int unsigned i = 0; i < DICT_ENTRY; i++) begin
            o_flat[i*WORD +: WORD] = mem_q[i];
        end
    end
`endif

endmodule

// File: rtl/decompress_stage1and2.sv
// Decompression front end: parses one variable-length code per cycle out of a 128-bit
// left-aligned bit buffer, rebuilds 32-bit words against the FIFO dictionary and emits them
// as {earlier, later} 64-bit pairs. Lines are 4 codes padded to a multiple of 64 bits.
// Optional: DECOMP_DICT_DEBUG_EN exposes o_dictionary_data.
module decompress_stage1and2
    import decomp_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset,
    decompress_stage1and2_if.slave     bus
`ifdef DECOMP_DICT_DEBUG_EN
    ,
    output logic [DICT_ENTRY*WORD-1:0] o_dictionary_data
`endif
);

    typedef enum logic [1:0] {StDecode, StPad, StError} state_e;

    localparam logic [7:0] ChunkBits = 8'(WIDTH);
    localparam logic [1:0] LastPos   = 2'(LINE_WORDS - 1);

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [7:0]       fill_q, fill_d;
    logic [1:0]       line_pos_q, line_pos_d;
    logic [5:0]       line_bits_q, line_bits_d;
    logic [5:0]       pad_q, pad_d;
    logic [WORD-1:0]  word0_q, word0_d;
    logic [WORD-1:0]  word1_q, word1_d;
    logic             slot_q, slot_d;
    logic             valid_q, valid_d;
    logic             line_done_q, line_done_d;
    logic             error_q, error_d;

    code_e            code;
    logic             hdr_ok;
    logic [7:0]       code_len;
    logic [IDX_W-1:0] dict_raddr;
    logic [WORD-1:0]  dict_rdata;
    logic [WORD-1:0]  dec_word;
    logic             dict_push;
    logic             dict_we;
    logic             blocked, fire, illegal, pad_fire, accept;
    logic [7:0]       shift_amt, fill_shift;
    logic [BUF_W-1:0] buf_shift;
    logic [5:0]       line_bits_sum;

    // Classify the code at the head of the buffer; 11-prefixed codes need 4 bits to tell apart.
    always_comb begin
        code   = CodeZzzz;
        hdr_ok = 1'b0;
        unique case (buf_q[127:126])
            PfxZzzz: begin code = CodeZzzz; hdr_ok = (fill_q >= 8'd2); end
            PfxXxxx: begin code = CodeXxxx; hdr_ok = (fill_q >= 8'd2); end
            PfxMmmm: begin code = CodeMmmm; hdr_ok = (fill_q >= 8'd2); end
            PfxExt: begin
                hdr_ok = (fill_q >= 8'd4);
                unique case (buf_q[125:124])
                    SfxMmxx: code = CodeMmxx;
                    SfxZzzx: code = CodeZzzx;
                    SfxMmmx: code = CodeMmmx;
                    SfxIll:  code = CodeIllegal;
                endcase
            end
        endcase
    end

    assign code_len   = code_length(code);
    assign dict_raddr = (code == CodeMmmm) ? buf_q[125:122] : buf_q[123:120];

    // Rebuild the decoded word from payload and dictionary entry.
    always_comb begin
        dec_word  = '0;
        dict_push = 1'b0;
        case (code)
            CodeXxxx: begin dec_word = buf_q[125:94]; dict_push = 1'b1; end
            CodeMmmm: dec_word = dict_rdata;
            CodeMmxx: begin dec_word = {dict_rdata[31:16], buf_q[119:104]}; dict_push = 1'b1; end
            CodeZzzx: dec_word = {24'h0, buf_q[123:116]};
            CodeMmmx: begin dec_word = {dict_rdata[31:8], buf_q[119:112]}; dict_push = 1'b1; end
            default:  dec_word = '0;
        endcase
    end

    assign blocked  = valid_q && !bus.i_ready;
    assign fire     = (state_q == StDecode) && hdr_ok && (code != CodeIllegal) &&
                      (fill_q >= code_len) && !blocked;
    assign illegal  = (state_q == StDecode) && hdr_ok && (code == CodeIllegal);
    assign pad_fire = (state_q == StPad) && (fill_q >= {2'b00, pad_q});
    assign accept   = bus.i_valid && bus.o_ready;
    assign dict_we  = fire && dict_push;
    assign line_bits_sum = line_bits_q + code_len[5:0];

    decomp_dictionary u_dict (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (dict_we),
        .i_wdata (dec_word),
        .i_raddr (dict_raddr),
        .o_rdata (dict_rdata)
`ifdef DECOMP_DICT_DEBUG_EN
        ,
        .o_flat  (o_dictionary_data)
`endif
    );

    // Buffer shift/append, pair register, line framing and FSM next state.
    always_comb begin
        state_d     = state_q;
        line_pos_d  = line_pos_q;
        line_bits_d = line_bits_q;
        pad_d       = pad_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        slot_d      = slot_q;
        valid_d     = valid_q && !bus.i_ready;
        line_done_d = 1'b0;
        error_d     = error_q;

        // Consumed bits leave first; an accepted chunk lands right behind what remains.
        shift_amt  = fire ? code_len : (pad_fire ? {2'b00, pad_q} : 8'd0);
        buf_shift  = buf_q << shift_amt;
        fill_shift = fill_q - shift_amt;
        buf_d      = buf_shift;
        fill_d     = fill_shift;
        if (accept) begin
            buf_d  = buf_shift | ({bus.i_chunk, {WIDTH{1'b0}}} >> fill_shift);
            fill_d = fill_shift + ChunkBits;
        end

        unique case (state_q)
            StDecode: begin
                if (illegal) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else if (fire) begin
                    if (!slot_q) begin
                        word0_d = dec_word;
                        slot_d  = 1'b1;
                    end else begin
                        word1_d = dec_word;
                        slot_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                    if (line_pos_q == LastPos) begin
                        line_pos_d  = '0;
                        line_bits_d = '0;
                        // Bits left to the next 64-bit boundary (0 when already aligned).
                        pad_d       = 6'd0 - line_bits_sum;
                        line_done_d = 1'b1;
                        state_d     = StPad;
                    end else begin
                        line_pos_d  = line_pos_q + 2'd1;
                        line_bits_d = line_bits_sum;
                    end
                end
            end
            StPad: begin
                if (pad_fire) state_d = StDecode;
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= StDecode;
            buf_q       <= '0;
            fill_q      <= '0;
            line_pos_q  <= '0;
            line_bits_q <= '0;
            pad_q       <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            slot_q      <= 1'b0;
            valid_q     <= 1'b0;
            line_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            line_pos_q  <= line_pos_d;
            line_bits_q <= line_bits_d;
            pad_q       <= pad_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            line_done_q <= line_done_d;
            error_q     <= error_d;
        end
    end

    assign bus.o_ready     = (fill_q <= ChunkBits) && !error_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_word      = {word0_q, word1_q};
    assign bus.o_line_done = line_done_q;
    assign bus.o_error     = error_q;

endmodule

// File: tb/tb_decompress_stage1and2.sv
// Directed bench for decompress_stage1and2: builds compressed lines bit by bit, streams them in
// 64-bit chunks and compares every output pair against hand-computed words.
module tb_decompress_stage1and2;
    import decomp_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          line_done_cnt = 0;
    logic [63:0] acc = '0;
    int          acc_n = 0;
    logic [63:0] chunk_q[$];
    logic [63:0] out_q[$];

    always #5 clk = ~clk;

    decompress_stage1and2_if bus ();

`ifdef DECOMP_DICT_DEBUG_EN
    logic [DICT_ENTRY*WORD-1:0] dict_data;
`endif

    decompress_stage1and2 dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef DECOMP_DICT_DEBUG_EN
        ,
        .o_dictionary_data (dict_data)
`endif
    );

    // Record consumed pairs and line-done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.o_valid && bus.i_ready) out_q.push_back(bus.o_word);
        if (bus.o_line_done) line_done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_q.delete();
    endtask

    task automatic put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            acc[63 - acc_n] = v[i];
            acc_n++;
            if (acc_n == 64) begin
                chunk_q.push_back(acc);
                acc   = '0;
                acc_n = 0;
            end
        end
    endtask

    task automatic end_line();
        if (acc_n != 0) chunk_q.push_back(acc);
        acc   = '0;
        acc_n = 0;
    endtask

    task automatic c_xxxx(input logic [31:0] w);
        put({30'd0, 2'b01, w}, 34);
    endtask
    task automatic c_mmmm(input logic [3:0] idx);
        put({58'd0, 2'b10, idx}, 6);
    endtask
    task automatic c_zzzz();
        put(64'd0, 2);
    endtask
    task automatic c_zzzx(input logic [7:0] b);
        put({52'd0, 4'b1101, b}, 12);
    endtask
    task automatic c_mmxx(input logic [3:0] idx, input logic [15:0] h);
        put({40'd0, 4'b1100, idx, h}, 24);
    endtask
    task automatic c_mmmx(input logic [3:0] idx, input logic [7:0] b);
        put({48'd0, 4'b1110, idx, b}, 16);
    endtask

    task automatic send_chunk(input logic [63:0] c);
        int t;
        t = 0;
        bus.i_valid = 1'b1;
        bus.i_chunk = c;
        while (!bus.o_ready && t < 200) begin
            wait_cycles(1);
            t++;
        end
        check("send_ready", 64'(bus.o_ready), 64'd1);
        wait_cycles(1);
        bus.i_valid = 1'b0;
    endtask

    task automatic send_all();
        while (chunk_q.size() != 0) send_chunk(chunk_q.pop_front());
    endtask

    task automatic expect_pair(input string tag, input logic [63:0] exp);
        logic [63:0] got;
        int t;
        t = 0;
        while (out_q.size() == 0 && t < 100) begin
            wait_cycles(1);
            t++;
        end
        got = (out_q.size() != 0) ? out_q.pop_front() : 64'hx;
        check(tag, got, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
        check({tag, "_word"}, bus.o_word, 64'd0);
        check({tag, "_line_done"}, 64'(bus.o_line_done), 64'd0);
        check({tag, "_error"}, 64'(bus.o_error), 64'd0);
        check({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    endtask

    initial begin
        int          ld0;
        logic [63:0] held;

        bus.i_valid = 1'b0;
        bus.i_chunk = '0;
        bus.i_ready = 1'b1;
        do_reset();
        check_reset_values("rst");

        // Mixed codes in one line: 54 bits + 10 pad.
        ld0 = line_done_cnt;
        c_xxxx(32'h12345678); c_mmmm(4'd0); c_zzzz(); c_zzzx(8'hAB); end_line();
        send_all();
        expect_pair("mixed_pair0", {32'h12345678, 32'h12345678});
        expect_pair("mixed_pair1", {32'h00000000, 32'h000000AB});
        wait_cycles(4);
        check("mixed_line_done", 64'(line_done_cnt - ld0), 64'd1);
`ifdef DECOMP_DICT_DEBUG_EN
        check("mixed_dict0", 64'(dict_data[31:0]), 64'h12345678);
`endif

        // Partial matches; mmxx result lands in dict[1] and feeds mmmx.
        c_mmxx(4'd0, 16'hBEEF); c_mmmx(4'd1, 8'hCD); c_zzzz(); c_zzzz(); end_line();
        send_all();
        expect_pair("partial_pair0", {32'h1234BEEF, 32'h1234BECD});
        expect_pair("partial_pair1", 64'd0);
        wait_cycles(4);
        check("partial_line_done", 64'(line_done_cnt - ld0), 64'd2);

        // xxxx straddles the chunk boundary (bits 36..69).
        c_zzzx(8'h11); c_zzzx(8'h22); c_zzzx(8'h33); c_xxxx(32'hDEADBEEF); end_line();
        send_chunk(chunk_q.pop_front());
        expect_pair("straddle_pair0", {32'h00000011, 32'h00000022});
        wait_cycles(10);
        check("straddle_held_q", 64'(out_q.size()), 64'd0);
        check("straddle_held_valid", 64'(bus.o_valid), 64'd0);
        send_all();
        expect_pair("straddle_pair1", {32'h00000033, 32'hDEADBEEF});

        // Back-pressure with a full pair register.
        bus.i_ready = 1'b0;
        c_xxxx(32'h11112222); c_xxxx(32'h33334444); c_xxxx(32'h55556666); c_xxxx(32'h77778888);
        end_line();
        send_all();
        held = {32'h11112222, 32'h33334444};
        for (int k = 0; k < 5; k++) begin
            check("bp_word", bus.o_word, held);
            check("bp_valid", 64'(bus.o_valid), 64'd1);
            check("bp_ready", 64'(bus.o_ready), 64'd0);
            wait_cycles(1);
        end
        check("bp_nothing_consumed", 64'(out_q.size()), 64'd0);
        bus.i_ready = 1'b1;
        expect_pair("bp_pair0", held);
        expect_pair("bp_pair1", {32'h55556666, 32'h77778888});

        // Reset in the middle of a line, then a dictionary wrap from a clean state.
        c_xxxx(32'hFFFFFFFF); c_xxxx(32'hFFFFFFFF); c_xxxx(32'hFFFFFFFF); c_xxxx(32'hFFFFFFFF);
        end_line();
        send_chunk(chunk_q.pop_front());
        wait_cycles(3);
        do_reset();
        chunk_q.delete();
        check_reset_values("midline_rst");

        for (int v = 1; v <= 17; v++) begin
            c_xxxx(32'(v));
            if (v % 4 == 0) end_line();
        end
        c_mmmm(4'd0); c_mmmm(4'd1); c_mmmm(4'd15); end_line();
        // 0xCAFEF00D must land at index 1 if the pointer wrapped to 1.
        c_xxxx(32'hCAFEF00D); c_mmmm(4'd1); c_mmmm(4'd2); c_zzzz(); end_line();
        send_all();
        for (int k = 0; k < 8; k++) begin
            expect_pair("wrap_fill", {32'(2 * k + 1), 32'(2 * k + 2)});
        end
        expect_pair("wrap_dict0", {32'd17, 32'd17});
        expect_pair("wrap_dict1_15", {32'd2, 32'd16});
        expect_pair("wrap_ptr", {32'hCAFEF00D, 32'hCAFEF00D});
        expect_pair("wrap_dict2", {32'd3, 32'd0});

        // Illegal code 1111 is sticky until reset.
        put({60'd0, 4'b1111}, 4); end_line();
        send_all();
        for (int t = 0; t < 20 && !bus.o_error; t++) wait_cycles(1);
        check("ill_error", 64'(bus.o_error), 64'd1);
        check("ill_ready", 64'(bus.o_ready), 64'd0);
        wait_cycles(5);
        check("ill_error_sticky", 64'(bus.o_error), 64'd1);
        check("ill_ready_sticky", 64'(bus.o_ready), 64'd0);
        check("ill_no_output", 64'(out_q.size()), 64'd0);
        do_reset();
        check_reset_values("ill_rst");

        // Dictionary must read back zero after reset.
        c_mmmm(4'd0); c_mmmm(4'd1); c_mmmm(4'd2); c_zzzz(); end_line();
        send_all();
        expect_pair("post_rst_pair0", 64'd0);
        expect_pair("post_rst_pair1", 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
